// File: rtl/axi4_burst_mem_responder.sv
// AXI4 burst slave backed by a word-addressed byte-lane memory.
// Independent single-outstanding write and read engines; INCR/FIXED bursts, SLVERR on malformed or out-of-range beats.
module axi4_burst_mem_responder #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int C_MEM_DEPTH        = 64
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    // write address channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]       AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                        AWLEN,
    input  logic [2:0]                        AWSIZE,
    input  logic [1:0]                        AWBURST,
    input  logic                              AWVALID,
    output logic                              AWREADY,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                              WLAST,
    input  logic                              WVALID,
    output logic                              WREADY,
    // write response channel
    output logic [C_S_AXI_ID_WIDTH-1:0]       BID,
    output logic [1:0]                        BRESP,
    output logic                              BVALID,
    input  logic                              BREADY,
    // read address channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]       ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                        ARLEN,
    input  logic [2:0]                        ARSIZE,
    input  logic [1:0]                        ARBURST,
    input  logic                              ARVALID,
    output logic                              ARREADY,
    // read data channel
    output logic [C_S_AXI_ID_WIDTH-1:0]       RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                        RRESP,
    output logic                              RLAST,
    output logic                              RVALID,
    input  logic                              RREADY
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int LANES = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;

    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(4 * C_MEM_DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    function automatic logic request_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

    function automatic logic out_of_range(input logic [AW-1:0] addr);
        return {1'b0, addr} >= ADDR_LIMIT;
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic fixed);
        return fixed ? addr : addr + AW'(4);
    endfunction

    // Holds both ready outputs low through reset and the release cycle.
    logic active_reg;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            active_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- write engine
    logic [1:0]                  w_state_reg;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_reg;
    logic [AW-1:0]               w_addr_reg;
    logic [7:0]                  w_len_reg;
    logic [7:0]                  w_cnt_reg;
    logic                        w_fixed_reg;
    logic                        w_req_bad_reg;
    logic                        w_err_reg;

    logic             aw_hs;
    logic             w_hs;
    logic             w_last_beat;
    logic             w_beat_oob;
    logic             w_beat_err;
    logic             mem_we;
    logic [IDX_W-1:0] w_idx;

    assign AWREADY     = active_reg && (w_state_reg == W_IDLE);
    assign WREADY      = (w_state_reg == W_DATA);
    assign BVALID      = (w_state_reg == W_RESP);
    assign BID         = BVALID ? w_id_reg : '0;
    assign BRESP       = (BVALID && w_err_reg) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign w_last_beat = (w_cnt_reg == w_len_reg);
    assign w_beat_oob  = out_of_range(w_addr_reg);
    assign w_beat_err  = w_req_bad_reg || w_beat_oob || (WLAST != w_last_beat);
    // A malformed request still consumes its beats but never touches memory.
    assign mem_we      = w_hs && !w_req_bad_reg && !w_beat_oob;
    assign w_idx       = w_addr_reg[IDX_W+1:2];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_reg   <= W_IDLE;
            w_id_reg      <= '0;
            w_addr_reg    <= '0;
            w_len_reg     <= '0;
            w_cnt_reg     <= '0;
            w_fixed_reg   <= 1'b0;
            w_req_bad_reg <= 1'b0;
            w_err_reg     <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_id_reg      <= AWID;
                        w_addr_reg    <= AWADDR;
                        w_len_reg     <= AWLEN;
                        w_cnt_reg     <= '0;
                        w_fixed_reg   <= (AWBURST == BURST_FIXED);
                        w_req_bad_reg <= request_bad(AWSIZE, AWBURST);
                        w_err_reg     <= 1'b0;
                        w_state_reg   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_err_reg  <= w_err_reg || w_beat_err;
                        w_addr_reg <= next_addr(w_addr_reg, w_fixed_reg);
                        w_cnt_reg  <= w_cnt_reg + 8'd1;
                        if (w_last_beat) begin
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- read engine
    logic [0:0]                  r_state_reg;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id_reg;
    logic [AW-1:0]               r_addr_reg;
    logic [7:0]                  r_len_reg;
    logic [7:0]                  r_cnt_reg;
    logic                        r_fixed_reg;
    logic                        r_req_bad_reg;

    logic                          ar_hs;
    logic                          r_hs;
    logic                          r_last_beat;
    logic                          r_beat_err;
    logic [IDX_W-1:0]              r_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

    assign ARREADY     = active_reg && (r_state_reg == R_IDLE);
    assign RVALID      = (r_state_reg == R_DATA);
    assign ar_hs       = ARVALID && ARREADY;
    assign r_hs        = RVALID && RREADY;
    assign r_last_beat = (r_cnt_reg == r_len_reg);
    assign r_beat_err  = r_req_bad_reg || out_of_range(r_addr_reg);
    assign r_idx       = r_addr_reg[IDX_W+1:2];

    assign RID   = RVALID ? r_id_reg : '0;
    assign RLAST = RVALID && r_last_beat;
    assign RRESP = (RVALID && r_beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign RDATA = (RVALID && !r_beat_err) ? rd_word : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_reg   <= R_IDLE;
            r_id_reg      <= '0;
            r_addr_reg    <= '0;
            r_len_reg     <= '0;
            r_cnt_reg     <= '0;
            r_fixed_reg   <= 1'b0;
            r_req_bad_reg <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_id_reg      <= ARID;
                        r_addr_reg    <= ARADDR;
                        r_len_reg     <= ARLEN;
                        r_cnt_reg     <= '0;
                        r_fixed_reg   <= (ARBURST == BURST_FIXED);
                        r_req_bad_reg <= request_bad(ARSIZE, ARBURST);
                        r_state_reg   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        r_addr_reg <= next_addr(r_addr_reg, r_fixed_reg);
                        r_cnt_reg  <= r_cnt_reg + 8'd1;
                        if (r_last_beat) begin
                            r_state_reg <= R_IDLE;
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- storage
    // One byte-wide array per lane gives native strobe masking; contents are never reset.
    // Reads index through the registered beat address, so a same-edge write is seen on the next beat.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] lane_mem [C_MEM_DEPTH];

        always_ff @(posedge ACLK) begin
            if (mem_we && WSTRB[gi]) begin
                lane_mem[w_idx] <= WDATA[gi*8 +: 8];
            end
        end

        assign rd_word[gi*8 +: 8] = lane_mem[r_idx];
    end

endmodule

// File: tb/tb_axi4_burst_mem_responder.sv
// Directed bench for axi4_burst_mem_responder: loopback, strobes/FIXED, backpressure, errors, reset.
module tb_axi4_burst_mem_responder;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [0:0]  AWID = '0;
    logic [9:0]  AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [0:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [0:0]  ARID = '0;
    logic [9:0]  ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [0:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    axi4_burst_mem_responder #(
        .C_S_AXI_ID_WIDTH   (1),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (10),
        .C_MEM_DEPTH        (64)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .AWID    (AWID),
        .AWADDR  (AWADDR),
        .AWLEN   (AWLEN),
        .AWSIZE  (AWSIZE),
        .AWBURST (AWBURST),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARID    (ARID),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARSIZE  (ARSIZE),
        .ARBURST (ARBURST),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [0:0]  rd_id [16];
    int          rd_count;
    int          rd_unstable;
    int          rd_stalls;
    logic [1:0]  b_resp;
    logic [0:0]  b_id;
    int          b_hold;

    // Inputs change on the falling edge; ready/valid seen there decide the next rising-edge handshake.
    task automatic do_write(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [0:0] id, input int last_at, input int bdelay);
        int n;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'b010; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == last_at); WVALID = 1'b1;
            n = 0;
            while (WREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) begin
                vectors++; miscompares++;
                $display("FAIL w_timeout beat %0d: WREADY=%b required 1", i, WREADY);
            end
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        b_hold = 0;
        for (int d = 0; d < bdelay; d++) begin
            if (BVALID === 1'b1) b_hold++;
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        n = 0;
        while (BVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
        end
        b_resp = BRESP; b_id = BID;
        @(negedge ACLK);
        BREADY = 1'b0;
        $display("write addr=%h len=%0d burst=%0d -> BRESP=%0d BID=%0d", addr, len, burst, b_resp, b_id);
    endtask

    task automatic do_read(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [0:0] id, input bit toggle, input int stop_after);
        int n;
        int cyc;
        bit stalled;
        logic [31:0] h_data;
        logic [1:0]  h_resp;
        logic        h_last;
        h_data = '0; h_resp = '0; h_last = 1'b0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        rd_count = 0; rd_unstable = 0; rd_stalls = 0; stalled = 1'b0; cyc = 0;
        while (rd_count <= int'(len) && rd_count < stop_after && cyc < 200) begin
            RREADY = toggle ? cyc[0] : 1'b1;
            if (RVALID === 1'b1) begin
                if (stalled && (RDATA !== h_data || RRESP !== h_resp || RLAST !== h_last)) rd_unstable++;
                if (RREADY) begin
                    rd_data[rd_count] = RDATA; rd_resp[rd_count] = RRESP;
                    rd_last[rd_count] = RLAST; rd_id[rd_count] = RID;
                    rd_count++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1; rd_stalls++;
                    h_data = RDATA; h_resp = RRESP; h_last = RLAST;
                end
            end
            @(negedge ACLK);
            cyc++;
        end
        RREADY = 1'b0;
        if (cyc >= 200) begin
            vectors++; miscompares++;
            $display("FAIL r_timeout: beats=%0d required %0d", rd_count, int'(len) + 1);
        end
        $display("read addr=%h len=%0d burst=%0d size=%0d -> %0d beats", addr, len, burst, size, rd_count);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge ACLK);
        vectors++;
        if ({AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RDATA, RRESP, RLAST, RID} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: AWREADY=%b ARREADY=%b RVALID=%b BVALID=%b RDATA=%h required all 0",
                     AWREADY, ARREADY, RVALID, BVALID, RDATA);
        end
        repeat (5) @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        vectors++;
        if (AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL release_cycle: AWREADY=%b ARREADY=%b required 0 0", AWREADY, ARREADY);
        end
        @(posedge ACLK);
        #1;
        vectors++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL after_release: AWREADY=%b ARREADY=%b required 1 1", AWREADY, ARREADY);
        end
        @(negedge ACLK);
        $display("reset test done");
    endtask

    task automatic test_loopback();
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(10'h000, 8'd7, 2'b01, 1'b1, 7, 0);
        vectors++;
        if (b_resp !== 2'b00 || b_id !== 1'b1) begin
            miscompares++;
            $display("FAIL loop_bresp: BRESP=%0d BID=%0d required 0 1", b_resp, b_id);
        end
        do_read(10'h000, 8'd7, 2'b01, 3'b010, 1'b1, 1'b0, 99);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd_data[i] !== 32'(i + 1) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 7) || rd_id[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL loop_beat%0d: RDATA=%h RRESP=%0d RLAST=%b RID=%0d required %h 0 %b 1",
                         i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], 32'(i + 1), (i == 7));
            end
        end
    endtask

    task automatic test_strobe_fixed();
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(10'h020, 8'd0, 2'b01, 1'b0, 0, 0);
        wd[0] = 32'h0000_00AA; ws[0] = 4'h1;
        wd[1] = 32'h0000_BB00; ws[1] = 4'h2;
        do_write(10'h020, 8'd1, 2'b00, 1'b0, 1, 0);
        vectors++;
        if (b_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL fixed_bresp: BRESP=%0d required 0", b_resp);
        end
        do_read(10'h020, 8'd0, 2'b01, 3'b010, 1'b0, 1'b0, 99);
        vectors++;
        if (rd_data[0] !== 32'hFFFF_BBAA || rd_last[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL strobe_merge: RDATA=%h RLAST=%b required ffffbbaa 1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h100 + 32'(i); ws[i] = 4'hF; end
        do_write(10'h040, 8'd7, 2'b01, 1'b0, 7, 5);
        vectors++;
        if (b_hold !== 5 || b_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL bvalid_hold: held=%0d BRESP=%0d required 5 0", b_hold, b_resp);
        end
        do_read(10'h040, 8'd7, 2'b01, 3'b010, 1'b0, 1'b1, 99);
        vectors++;
        if (rd_unstable !== 0 || rd_stalls < 8) begin
            miscompares++;
            $display("FAIL stall_stable: unstable=%0d stalls=%0d required 0 >=8", rd_unstable, rd_stalls);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd_data[i] !== 32'h100 + 32'(i) || rd_last[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL bp_beat%0d: RDATA=%h RLAST=%b required %h %b",
                         i, rd_data[i], rd_last[i], 32'h100 + 32'(i), (i == 7));
            end
        end
    endtask

    task automatic test_errors();
        wd[0] = 32'hA5A5_A5A5; ws[0] = 4'hF;
        wd[1] = 32'h5A5A_5A5A; ws[1] = 4'hF;
        do_write(10'h0FC, 8'd1, 2'b01, 1'b0, 1, 0);
        vectors++;
        if (b_resp !== 2'b10) begin
            miscompares++;
            $display("FAIL oob_bresp: BRESP=%0d required 2", b_resp);
        end
        do_read(10'h0FC, 8'd1, 2'b01, 3'b010, 1'b0, 1'b0, 99);
        vectors++;
        if (rd_data[0] !== 32'hA5A5_A5A5 || rd_resp[0] !== 2'b00 || rd_last[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL oob_rd_beat0: RDATA=%h RRESP=%0d RLAST=%b required a5a5a5a5 0 0",
                     rd_data[0], rd_resp[0], rd_last[0]);
        end
        vectors++;
        if (rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b10 || rd_last[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_rd_beat1: RDATA=%h RRESP=%0d RLAST=%b required 0 2 1",
                     rd_data[1], rd_resp[1], rd_last[1]);
        end
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h11 * 32'(i + 1); ws[i] = 4'hF; end
        do_write(10'h080, 8'd3, 2'b01, 1'b0, 1, 0);
        vectors++;
        if (b_resp !== 2'b10) begin
            miscompares++;
            $display("FAIL wlast_bresp: BRESP=%0d required 2", b_resp);
        end
        do_read(10'h080, 8'd3, 2'b01, 3'b010, 1'b0, 1'b0, 99);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rd_data[i] !== 32'h11 * 32'(i + 1) || rd_resp[i] !== 2'b00) begin
                miscompares++;
                $display("FAIL wlast_data%0d: RDATA=%h RRESP=%0d required %h 0",
                         i, rd_data[i], rd_resp[i], 32'h11 * 32'(i + 1));
            end
        end
        do_read(10'h000, 8'd0, 2'b01, 3'b001, 1'b0, 1'b0, 99);
        vectors++;
        if (rd_resp[0] !== 2'b10 || rd_data[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL size_err: RRESP=%0d RDATA=%h required 2 0", rd_resp[0], rd_data[0]);
        end
        do_read(10'h000, 8'd1, 2'b10, 3'b010, 1'b0, 1'b0, 99);
        vectors++;
        if (rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 || rd_count !== 2) begin
            miscompares++;
            $display("FAIL wrap_err: RRESP=%0d,%0d beats=%0d required 2,2 2", rd_resp[0], rd_resp[1], rd_count);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_read(10'h000, 8'd7, 2'b01, 3'b010, 1'b0, 1'b0, 4);
        vectors++;
        if (RVALID !== 1'b1 || rd_data[3] !== 32'd4) begin
            miscompares++;
            $display("FAIL pre_abort: RVALID=%b beat3=%h required 1 4", RVALID, rd_data[3]);
        end
        ARESETN = 1'b0;
        #1;
        vectors++;
        if (RVALID !== 1'b0 || RDATA !== 32'h0 || ARREADY !== 1'b0 || AWREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: RVALID=%b RDATA=%h ARREADY=%b AWREADY=%b required 0 0 0 0",
                     RVALID, RDATA, ARREADY, AWREADY);
        end
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        do_read(10'h000, 8'd7, 2'b01, 3'b010, 1'b1, 1'b0, 99);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (rd_data[i] !== 32'(i + 1) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 7)) begin
                miscompares++;
                $display("FAIL post_reset_beat%0d: RDATA=%h RRESP=%0d RLAST=%b required %h 0 %b",
                         i, rd_data[i], rd_resp[i], rd_last[i], 32'(i + 1), (i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_strobe_fixed();
        test_backpressure();
        test_errors();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
